// File: rtl/fp16_pkg.sv
// Shared fp16 constants, accumulator FSM state type and field classifiers
// used by the dot-product accumulator and its adder.
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  localparam int FP16_BIAS  = 15;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  // Subnormals carry a zero exponent field and are deliberately treated as signed zero.
  function automatic logic fp16_is_zero(input logic [15:0] x);
    return x[14:10] == 5'h00;
  endfunction

endpackage

// File: rtl/fp16_dot_accum_if.sv
// Term stream in, finished-sum stream out, plus abort and term index,
// bundled for the accumulator (slave) and whatever feeds/drains it (master).
interface fp16_dot_accum_if
  import fp16_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = $clog2(N_TERMS)
);

  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             clear;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_ready;
  logic [CNT_W-1:0] term_idx;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, out_data, term_idx
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, out_data, term_idx
  );

endinterface

// File: rtl/fp16_dot_accum_add.sv
// Combinational binary16 adder: exact alignment with guard/round/sticky,
// round-to-nearest-even, subnormals in and out flushed to signed zero.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic                  sa, sb;
  logic [FP16_EXP_W-1:0] ea, eb;
  logic [FP16_MAN_W-1:0] ma, mb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa     = a[15];
  assign sb     = b[15];
  assign ea     = a[14:10];
  assign eb     = b[14:10];
  assign ma     = a[9:0];
  assign mb     = b[9:0];
  assign a_nan  = fp16_is_nan(a);
  assign b_nan  = fp16_is_nan(b);
  assign a_inf  = fp16_is_inf(a);
  assign b_inf  = fp16_is_inf(b);
  assign a_zero = fp16_is_zero(a);
  assign b_zero = fp16_is_zero(b);

  logic              swap;
  logic              s_big, s_small;
  logic [4:0]        e_big, e_small;
  logic [9:0]        m_big, m_small;
  logic [4:0]        diff;
  logic [13:0]       big_ext, small_ext, small_al;
  logic              sticky;
  logic [14:0]       raw;
  logic [13:0]       norm;
  logic [3:0]        lz;
  logic signed [6:0] exp_n, exp_r;
  logic              round_up;
  logic [11:0]       rounded;
  logic [9:0]        man_r;
  logic [15:0]       finite_sum;

  // Finite datapath: the larger magnitude is the reference, so the
  // difference is never negative and the result takes its sign.
  always_comb begin
    swap       = {eb, mb} > {ea, ma};
    s_big      = swap ? sb : sa;
    s_small    = swap ? sa : sb;
    e_big      = swap ? eb : ea;
    e_small    = swap ? ea : eb;
    m_big      = swap ? mb : ma;
    m_small    = swap ? ma : mb;
    diff       = e_big - e_small;
    big_ext    = {1'b1, m_big, 3'b000};
    small_ext  = {1'b1, m_small, 3'b000};
    small_al   = 14'd0;
    sticky     = 1'b0;
    raw        = 15'd0;
    norm       = 14'd0;
    lz         = 4'd0;
    exp_n      = 7'sd0;
    exp_r      = 7'sd0;
    round_up   = 1'b0;
    rounded    = 12'd0;
    man_r      = 10'd0;
    finite_sum = 16'h0000;

    if (diff >= 5'd14) begin
      small_al = 14'd0;
      sticky   = 1'b1;
    end else begin
      small_al = small_ext >> diff;
      sticky   = |(small_ext & ~(14'h3FFF << diff));
    end
    small_al[0] = small_al[0] | sticky;

    if (s_big == s_small)
      raw = {1'b0, big_ext} + {1'b0, small_al};
    else
      raw = {1'b0, big_ext} - {1'b0, small_al};

    exp_n = $signed({2'b00, e_big});
    if (raw[14]) begin
      norm  = raw[14:1] | {13'd0, raw[0]};
      exp_n = exp_n + 7'sd1;
    end else begin
      for (int i = 0; i < 14; i++)
        if (raw[i]) lz = 4'(13 - i);
      norm  = raw[13:0] << lz;
      exp_n = exp_n - $signed({3'b000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[13:3]} + {11'd0, round_up};
    if (rounded[11]) begin
      exp_r = exp_n + 7'sd1;
      man_r = rounded[10:1];
    end else begin
      exp_r = exp_n;
      man_r = rounded[9:0];
    end

    // Exact cancellation is always +0; underflow keeps the sign of the result.
    if (raw == 15'd0)
      finite_sum = 16'h0000;
    else if (exp_r >= 7'sd31)
      finite_sum = s_big ? FP16_NINF : FP16_PINF;
    else if (exp_r <= 7'sd0)
      finite_sum = {s_big, 15'd0};
    else
      finite_sum = {s_big, exp_r[4:0], man_r};
  end

  always_comb begin
    sum = finite_sum;
    if (a_nan || b_nan)
      sum = FP16_QNAN;
    else if (a_inf && b_inf && (sa != sb))
      sum = FP16_QNAN;
    else if (a_inf)
      sum = sa ? FP16_NINF : FP16_PINF;
    else if (b_inf)
      sum = sb ? FP16_NINF : FP16_PINF;
    else if (a_zero && b_zero)
      sum = {sa & sb, 15'd0};
    else if (a_zero)
      sum = b;
    else if (b_zero)
      sum = a;
  end

endmodule

// File: rtl/fp16_dot_accum.sv
// Sums N_TERMS fp16 products from a valid/ready stream into one result and
// holds it on a valid/ready output until downstream takes it.
module fp16_dot_accum
  import fp16_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = $clog2(N_TERMS)
) (
  input logic            clk,
  input logic            rst,
  fp16_dot_accum_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      acc;
  logic [15:0]      out_data;
  logic             out_valid;
  logic [15:0]      sum_next;

  fp16_add u_add (
    .a   (acc),
    .b   (bus.in_data),
    .sum (sum_next)
  );

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.term_idx  = cnt;

  // The first term is loaded raw so a leading -0 survives; clear only acts
  // while accumulating, so a held result can never be discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= 16'h0000;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.clear) begin
            cnt <= '0;
            acc <= 16'h0000;
          end else if (bus.in_valid) begin
            acc <= (cnt == '0) ? bus.in_data : sum_next;
            if (cnt == LAST) begin
              out_data  <= sum_next;
              out_valid <= 1'b1;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_dot_accum.sv
// Self-checking bench for fp16_dot_accum: directed vectors, specials,
// handshake corner cases and randomized dot products against a real-valued model.
module tb_fp16_dot_accum;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  fp16_dot_accum_if #(.N_TERMS(4)) bus ();

  fp16_dot_accum #(.N_TERMS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic works on exact real values, then rounds to binary16.
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r * 0.5;
    return r;
  endfunction

  function automatic real val16(input logic [15:0] x);
    real v;
    if (x[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(x[9:0]) / 1024.0) * pow2(int'(x[14:10]) - 15);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf, sgn;
    real  s, mag, q, frac;
    int   e, iq;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h7E00;
    if (a_inf) return {a[15], 15'h7C00};
    if (b_inf) return {b[15], 15'h7C00};
    s = val16(a) + val16(b);
    if (s == 0.0) begin
      if (a[14:10] == 0 && b[14:10] == 0) return {a[15] & b[15], 15'd0};
      return 16'h0000;
    end
    sgn = (s < 0.0);
    mag = sgn ? -s : s;
    e = 0;
    while (mag >= pow2(e + 1)) e++;
    while (mag < pow2(e)) e--;
    q    = mag / pow2(e - 10);
    iq   = $rtoi(q);
    frac = q - real'(iq);
    if (frac > 0.5 || (frac == 0.5 && (iq % 2) == 1)) iq++;
    if (iq == 2048) begin
      iq = 1024;
      e++;
    end
    if (e > 15) return {sgn, 15'h7C00};
    if (e < -14) return {sgn, 15'd0};
    return {sgn, 5'(e + 15), 10'(iq - 1024)};
  endfunction

  function automatic logic [15:0] rand_term();
    int k;
    k = $urandom_range(0, 99);
    if (k < 4)       return {1'($urandom), 15'd0};
    else if (k < 7)  return {1'($urandom), 5'd0, 10'($urandom_range(1, 1023))};
    else if (k < 9)  return {1'($urandom), 5'h1F, 10'd0};
    else if (k < 10) return {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
    else if (k < 22) return {1'($urandom), 5'($urandom_range(1, 4)), 10'($urandom)};
    else if (k < 30) return {1'($urandom), 5'($urandom_range(27, 30)), 10'($urandom)};
    else             return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  task automatic send_term(input logic [15:0] d);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      $display("[TB] FAIL send_term timeout: in_ready got %b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_dot(input string name, input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] expv);
    logic [15:0] t [4];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.term_idx !== 2'(i))
        $display("[TB] FAIL %s term_idx: got %0d required %0d", name, bus.term_idx, i);
      else n_pass++;
      send_term(t[i]);
      if (i < 3) begin
        n_checks++;
        if (bus.out_valid !== 1'b0)
          $display("[TB] FAIL %s early out_valid: got %b required 0", name, bus.out_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.out_valid !== 1'b1)
      $display("[TB] FAIL %s out_valid: got %b required 1", name, bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_data !== expv)
      $display("[TB] FAIL %s out_data: got %h required %h", name, bus.out_data, expv);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0)
      $display("[TB] FAIL %s in_ready in hold: got %b required 0", name, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("[TB] FAIL %s release: got valid=%b ready=%b required valid=0 ready=1",
               name, bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b required 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_data !== 16'h0000) $display("[TB] FAIL reset out_data: got %h required 0000", bus.out_data);
    else n_pass++;
    n_checks++;
    if (bus.term_idx !== 2'd0) $display("[TB] FAIL reset term_idx: got %0d required 0", bus.term_idx);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b required 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_dot("mult_stream", 16'hBC08, 16'h7098, 16'hEA62, 16'hEC92, 16'h65B4);
    run_dot("round_ties",  16'h6400, 16'h3800, 16'h3C00, 16'h3800, 16'h6402);
  endtask

  task automatic test_specials();
    run_dot("overflow",      16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 16'h7C00);
    run_dot("ovf_tie",       16'h7BFF, 16'h4C00, 16'h0000, 16'h0000, 16'h7C00);
    run_dot("max_no_ovf",    16'h7BFF, 16'h4800, 16'h0000, 16'h0000, 16'h7BFF);
    run_dot("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h3C00, 16'h3C00, 16'h7E00);
    run_dot("ninf_finite",   16'hFC00, 16'h3C00, 16'h7BFF, 16'h0000, 16'hFC00);
    run_dot("cancel",        16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 16'h0000);
    run_dot("nan_mid",       16'h3C00, 16'h7E01, 16'h3C00, 16'h3C00, 16'h7E00);
    run_dot("nan_first",     16'h7E01, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7E00);
    run_dot("neg_zeros",     16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_dot("mixed_zeros",   16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000);
    run_dot("flush_neg",     16'h0400, 16'h8401, 16'h8000, 16'h8000, 16'h8000);
    run_dot("subnormals",    16'h83FF, 16'h83FF, 16'h8000, 16'h8000, 16'h8000);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_term(16'h3C00);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4000;
    for (int c = 0; c < 3; c++) begin
      bus.clear = (c == 1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4400)
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b data=%h required valid=1 data=4400",
                 c, bus.out_valid, bus.out_data);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.term_idx !== 2'd0)
        $display("[TB] FAIL bp_stall cycle %0d: got ready=%b idx=%0d required ready=0 idx=0",
                 c, bus.in_ready, bus.term_idx);
      else n_pass++;
    end
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.term_idx !== 2'd0 || bus.in_ready !== 1'b1)
      $display("[TB] FAIL bp_release: got valid=%b idx=%0d ready=%b required valid=0 idx=0 ready=1",
               bus.out_valid, bus.term_idx, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.term_idx !== 2'd1) $display("[TB] FAIL bp_accept: got idx=%0d required 1", bus.term_idx);
    else n_pass++;
    for (int i = 0; i < 3; i++) send_term(16'h4000);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4800)
      $display("[TB] FAIL bp_next_sum: got valid=%b data=%h required valid=1 data=4800",
               bus.out_valid, bus.out_data);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b1;
    send_term(16'h4400);
    send_term(16'h4400);
    n_checks++;
    if (bus.term_idx !== 2'd2) $display("[TB] FAIL clear_pre idx: got %0d required 2", bus.term_idx);
    else n_pass++;
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7BFF;
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.term_idx !== 2'd0 || bus.out_valid !== 1'b0)
      $display("[TB] FAIL clear_post: got idx=%0d valid=%b required idx=0 valid=0",
               bus.term_idx, bus.out_valid);
    else n_pass++;
    run_dot("after_clear", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400);
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_term(16'h3C00);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.term_idx !== 2'd0)
      $display("[TB] FAIL async_reset: got valid=%b data=%h idx=%0d required 0/0000/0",
               bus.out_valid, bus.out_data, bus.term_idx);
    else n_pass++;
    rst = 1'b0;
    #1;
    run_dot("post_reset", 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4500);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] t [4];
      logic [15:0] m;
      string       nm;
      t[0] = rand_term();
      m    = t[0];
      for (int i = 1; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) t[i] = m ^ 16'h8000;
        else t[i] = rand_term();
        m = ref_add(m, t[i]);
      end
      nm = $sformatf("random%0d", n);
      run_dot(nm, t[0], t[1], t[2], t[3], m);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_specials();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_dot_accum.md
Name: fp16_dot_accum

Overview:
- Downstream consumer of the fp16 multiplier (fpm).
- Accepts a stream of half-precision products over a valid/ready handshake and sums N_TERMS of them into one fp16 dot-product result, for example one matrix-row × vertex product in the vertex shader transform path.
- Holds each finished sum on a valid/ready output until the next stage takes it.

Parameters:
- N_TERMS, 4, number of products summed per result (≥2).
- CNT_W, $clog2(N_TERMS), width of the term counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a product is presented on in_data.
- in_data  input  16  fp16 product (IEEE binary16 layout).
- in_ready  output  1  block can accept a term this cycle.
- clear  input  1  synchronous abort of the current partial sum.
- out_valid  output  1  out_data holds a finished sum.
- out_data  output  16  fp16 dot-product result.
- out_ready  input  1  downstream accepts out_data.
- term_idx  output  CNT_W  index of the next term to be accepted.

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=16'h0000, in_ready=1 once rst is released.
- States: ACCUM and HOLD. in_ready = (state==ACCUM).
- ACCUM, transfer when in_valid && in_ready:
  - cnt==0: acc <= in_data. The first term is loaded unmodified, so -0 stays -0.
  - cnt>0: acc <= fp16_add(acc, in_data).
  - cnt increments on each transfer.
- Last term (cnt==N_TERMS-1):
  - out_data <= the final sum, out_valid <= 1, cnt <= 0, state <= HOLD.
  - Latency: out_valid rises on the first edge after the last term is accepted.
- HOLD:
  - out_data and out_valid are held stable while out_ready=0.
  - in_ready=0; no term is accepted in the cycle out_valid && out_ready is high.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM.
  - Maximum throughput: one result per N_TERMS+1 cycles.
- clear=1 in ACCUM: cnt <= 0, acc <= 0, and any same-cycle in_valid is dropped.
- clear=1 in HOLD: ignored; the pending result is never lost.
- in_valid with in_ready=0: no effect; the upstream stage holds its data.
- fp16_add arithmetic rules:
  - Exact alignment with guard/round/sticky bits; round-to-nearest-even.
  - Subnormal inputs are treated as signed zero. A result magnitude below 2^-14 flushes to zero carrying the result sign.
  - x + (-x) = +0. (+0) + (-0) = +0. (-0) + (-0) = -0.
  - Overflow past 65504 after rounding gives ±Inf (7C00/FC00).
  - Inf + finite = Inf. Inf + (-Inf) = 7E00.
  - Any NaN input gives the canonical 7E00.
- term_idx = cnt.

Decomposition:
- Shared package fp16_pkg:
  - FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00.
  - FP16_BIAS=15, FP16_EXP_W=5, FP16_MAN_W=10.
  - State enum {ACCUM, HOLD}.
- One combinational sub-module, fp16_add (a, b → sum), implementing the rules above.
- fp16_dot_accum owns the counter, the FSM, the accumulator register and the handshake.

Test Plan:
- Multiplier output stream BC08, 7098, EA62, EC92 with out_ready=1 → partial sums 7098, 6DFF; out_data=65B4 (1460.0); out_valid high one cycle after the 4th transfer.
- Rounding ties 6400, 3800, 3C00, 3800 → partials 6400, 6401; final out_data=6402.
- Specials:
  - 7BFF, 7BFF, 0000, 0000 → 7C00.
  - 7C00, FC00, 3C00, 3C00 → 7E00.
  - 3C00, BC00, 0000, 0000 → 0000.
  - 7E01 as any term → 7E00.
- Backpressure: 3C00 ×4, out_ready=0 for 3 cycles → out_data=4400 stable, in_valid held high is not accepted (in_ready=0); out_ready=1 → out_valid drops next edge, next term accepted the cycle after.
- clear after 2 terms of 4400, then 3C00 ×4 → out_data=4400, term_idx back to 0 after clear.
- rst asserted mid-accumulation (after 3 terms), asynchronously between edges → out_valid=0, out_data=0000, term_idx=0 immediately; the next 4 terms produce a fresh correct sum.
